// File: rtl/lab3_mem_blocking_cache_base_ctrl.sv
// Control unit for a blocking, direct-mapped, write-back cache with 16-byte lines.
// Tracks per-line valid/dirty bits and sequences tag check, eviction, refill and response.
module lab3_mem_blocking_cache_base_ctrl #(
  parameter int unsigned size = 256
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cachereq_val,
  output logic        cachereq_rdy,
  output logic        cacheresp_val,
  input  logic        cacheresp_rdy,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic        memresp_val,
  output logic        memresp_rdy,

  output logic        cachereq_en,
  output logic        memresp_en,
  output logic        refill_mux_sel,
  output logic        tag_array_wen,
  output logic        tag_array_ren,
  output logic        data_array_wen,
  output logic        data_array_ren,
  output logic        read_data_reg_en,
  output logic        read_tag_reg_en,
  output logic        memreq_tag_mux_sel,
  output logic [15:0] data_array_wben,
  output logic [1:0]  read_byte_mux_sel,
  output logic [2:0]  cacheresp_type,
  output logic [2:0]  memreq_type,

  input  logic [2:0]  cachereq_type,
  input  logic [31:0] cachereq_addr,
  input  logic        tag_match
);

  localparam int unsigned nblocks = size * 8 / 128;
  localparam int unsigned idw     = $clog2(nblocks);

  typedef enum logic [3:0] {
    StIdle, StTc, StInit, StRd, StWr, StEp, StEr, StEw, StRr, StRw, StRu, StWait
  } state_e;

  state_e             state;
  logic [nblocks-1:0] valid;
  logic [nblocks-1:0] dirty;
  logic [idw-1:0]     idx;
  logic [1:0]         off;
  logic               hit;
  logic               unused_addr;

  assign idx         = cachereq_addr[idw+3:4];
  assign off         = cachereq_addr[3:2];
  assign hit         = tag_match & valid[idx];
  assign unused_addr = ^{cachereq_addr[31:idw+4], cachereq_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
      valid <= '0;
      dirty <= '0;
    end else begin
      unique case (state)
        StIdle: if (cachereq_val) state <= StTc;
        StTc: begin
          if (cachereq_type == 3'd2)                 state <= StInit;
          else if (hit && cachereq_type == 3'd0)     state <= StRd;
          else if (hit && cachereq_type == 3'd1)     state <= StWr;
          else if (valid[idx] && dirty[idx])         state <= StEp;
          else                                       state <= StRr;
        end
        StInit: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b1;
          state      <= StWait;
        end
        StRd: state <= StWait;
        StWr: begin
          dirty[idx] <= 1'b1;
          state      <= StWait;
        end
        StEp: state <= StEr;
        StEr: if (memreq_rdy) state <= StEw;
        // Write ack carries no data; only the handshake matters.
        StEw: if (memresp_val) state <= StRr;
        StRr: if (memreq_rdy) state <= StRw;
        StRw: if (memresp_val) state <= StRu;
        // Retry the tag check after refill so the hit path completes the request.
        StRu: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state      <= StTc;
        end
        StWait: if (cacheresp_rdy) state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    cachereq_rdy       = (state == StIdle);
    cacheresp_val      = 1'b0;
    memreq_val         = 1'b0;
    memresp_rdy        = 1'b0;
    cachereq_en        = 1'b0;
    memresp_en         = 1'b0;
    refill_mux_sel     = 1'b0;
    tag_array_wen      = 1'b0;
    tag_array_ren      = 1'b0;
    data_array_wen     = 1'b0;
    data_array_ren     = 1'b0;
    read_data_reg_en   = 1'b0;
    read_tag_reg_en    = 1'b0;
    memreq_tag_mux_sel = 1'b0;
    data_array_wben    = 16'h0000;
    read_byte_mux_sel  = 2'd0;
    cacheresp_type     = 3'd0;
    memreq_type        = 3'd0;
    // Reset masks every control so an abandoned miss drives nothing.
    if (!reset) begin
      unique case (state)
        StIdle: cachereq_en = cachereq_val;
        StTc: begin
          tag_array_ren   = 1'b1;
          read_tag_reg_en = 1'b1;
        end
        StInit: begin
          data_array_wen  = 1'b1;
          data_array_wben = 16'h000F << {off, 2'b00};
          tag_array_wen   = 1'b1;
        end
        StRd, StEp: begin
          data_array_ren   = 1'b1;
          read_data_reg_en = 1'b1;
        end
        StWr: begin
          data_array_wen  = 1'b1;
          data_array_wben = 16'h000F << {off, 2'b00};
        end
        StEr: begin
          memreq_val  = 1'b1;
          memreq_type = 3'd1;
        end
        StEw: memresp_rdy = 1'b1;
        StRr: begin
          memreq_val         = 1'b1;
          memreq_tag_mux_sel = 1'b1;
        end
        StRw: begin
          memresp_rdy = 1'b1;
          memresp_en  = memresp_val;
        end
        StRu: begin
          data_array_wen  = 1'b1;
          refill_mux_sel  = 1'b1;
          data_array_wben = 16'hFFFF;
          tag_array_wen   = 1'b1;
        end
        StWait: begin
          cacheresp_val     = 1'b1;
          cacheresp_type    = cachereq_type;
          read_byte_mux_sel = off;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab3_mem_blocking_cache_base_ctrl.sv
// Directed bench for the blocking cache controller; a small tag-array model supplies tag_match.
module tb_lab3_mem_blocking_cache_base_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic        cachereq_en, memresp_en, refill_mux_sel, tag_array_wen, tag_array_ren;
  logic        data_array_wen, data_array_ren, read_data_reg_en, read_tag_reg_en;
  logic        memreq_tag_mux_sel;
  logic [15:0] data_array_wben;
  logic [1:0]  read_byte_mux_sel;
  logic [2:0]  cacheresp_type, memreq_type, cachereq_type;
  logic [31:0] cachereq_addr;
  logic        tag_match;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lab3_mem_blocking_cache_base_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .cachereq_val       (cachereq_val),
    .cachereq_rdy       (cachereq_rdy),
    .cacheresp_val      (cacheresp_val),
    .cacheresp_rdy      (cacheresp_rdy),
    .memreq_val         (memreq_val),
    .memreq_rdy         (memreq_rdy),
    .memresp_val        (memresp_val),
    .memresp_rdy        (memresp_rdy),
    .cachereq_en        (cachereq_en),
    .memresp_en         (memresp_en),
    .refill_mux_sel     (refill_mux_sel),
    .tag_array_wen      (tag_array_wen),
    .tag_array_ren      (tag_array_ren),
    .data_array_wen     (data_array_wen),
    .data_array_ren     (data_array_ren),
    .read_data_reg_en   (read_data_reg_en),
    .read_tag_reg_en    (read_tag_reg_en),
    .memreq_tag_mux_sel (memreq_tag_mux_sel),
    .data_array_wben    (data_array_wben),
    .read_byte_mux_sel  (read_byte_mux_sel),
    .cacheresp_type     (cacheresp_type),
    .memreq_type        (memreq_type),
    .cachereq_type      (cachereq_type),
    .cachereq_addr      (cachereq_addr),
    .tag_match          (tag_match)
  );

  // Datapath tag array stand-in: 16 lines, tag = addr[31:8], never cleared by reset.
  logic [23:0] tag_mem [16] = '{default: 24'hFFFFFF};
  always @(posedge clk) if (tag_array_wen) tag_mem[cachereq_addr[7:4]] <= cachereq_addr[31:8];
  assign tag_match = (tag_mem[cachereq_addr[7:4]] == cachereq_addr[31:8]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] typ, input logic [31:0] addr);
    cachereq_type = typ;
    cachereq_addr = addr;
    cachereq_val  = 1'b1;
    #1;
    check("accept_rdy", 32'(cachereq_rdy), 32'd1);
    check("accept_en", 32'(cachereq_en), 32'd1);
    tick();
    cachereq_val = 1'b0;
  endtask

  // Called in the cycle after accept (lat 1); stops with the DUT in WAIT.
  task automatic wait_resp(output int lat, output int nrd, output int nwr,
                           output logic wr_first, output logic [15:0] wb,
                           output logic [2:0] rtype, output logic [1:0] rsel);
    logic got;
    got = 1'b0; lat = 1; nrd = 0; nwr = 0; wr_first = 1'b0; wb = 16'h0;
    rtype = 3'd7; rsel = 2'd3;
    for (int i = 0; i < 60 && !got; i++) begin
      if (memreq_val && memreq_rdy) begin
        if (memreq_type == 3'd1) begin
          if (nrd == 0 && nwr == 0) wr_first = 1'b1;
          nwr++;
          check("evict_tag_sel", 32'(memreq_tag_mux_sel), 32'd0);
        end else begin
          nrd++;
          check("refill_tag_sel", 32'(memreq_tag_mux_sel), 32'd1);
        end
      end
      if (data_array_wen && !refill_mux_sel) wb = data_array_wben;
      if (cacheresp_val) begin
        got   = 1'b1;
        rtype = cacheresp_type;
        rsel  = read_byte_mux_sel;
      end else begin
        tick();
        lat++;
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic complete();
    check("wait_rdy_low", 32'(cachereq_rdy), 32'd0);
    tick();
    check("idle_rdy", 32'(cachereq_rdy), 32'd1);
  endtask

  int          lat, nrd, nwr;
  logic        wf;
  logic [15:0] wb;
  logic [2:0]  rt;
  logic [1:0]  rs;

  initial begin
    reset = 1'b1; cachereq_val = 1'b0; cachereq_type = 3'd0; cachereq_addr = 32'h0;
    cacheresp_rdy = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1;
    tick(); tick();
    check("rst_rdy", 32'(cachereq_rdy), 32'd1);
    check("rst_memreq", 32'(memreq_val), 32'd0);
    check("rst_resp", 32'(cacheresp_val), 32'd0);
    check("rst_memresp_rdy", 32'(memresp_rdy), 32'd0);
    reset = 1'b0;
    tick();

    // Init 0x1004 (idx 0, word 1)
    accept(3'd2, 32'h0000_1004);
    check("tc_tag_ren", 32'(tag_array_ren), 32'd1);
    check("tc_tag_reg", 32'(read_tag_reg_en), 32'd1);
    tick();
    check("init_wen", 32'(data_array_wen), 32'd1);
    check("init_wben", 32'(data_array_wben), 32'h00F0);
    check("init_tag_wen", 32'(tag_array_wen), 32'd1);
    check("init_refill_sel", 32'(refill_mux_sel), 32'd0);
    tick();
    check("init_resp_val", 32'(cacheresp_val), 32'd1);
    check("init_resp_type", 32'(cacheresp_type), 32'd2);
    check("init_byte_sel", 32'(read_byte_mux_sel), 32'd1);
    complete();

    // Read hit on the initialised word
    accept(3'd0, 32'h0000_1004);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("rdhit_lat", 32'(lat), 32'd3);
    check("rdhit_memreq", 32'(nrd + nwr), 32'd0);
    check("rdhit_type", 32'(rt), 32'd0);
    check("rdhit_sel", 32'(rs), 32'd1);
    complete();

    // Cold read, idx 2: TC RR RW RU TC RD WAIT
    accept(3'd0, 32'h0000_2020);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("cold_lat", 32'(lat), 32'd7);
    check("cold_nrd", 32'(nrd), 32'd1);
    check("cold_nwr", 32'(nwr), 32'd0);
    check("cold_sel", 32'(rs), 32'd0);
    complete();

    // Write miss, idx 3 word 2: refill then write
    accept(3'd1, 32'h0000_3038);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("wrmiss_lat", 32'(lat), 32'd7);
    check("wrmiss_nrd", 32'(nrd), 32'd1);
    check("wrmiss_wben", 32'(wb), 32'h0F00);
    check("wrmiss_type", 32'(rt), 32'd1);
    complete();

    // Conflicting read, same idx, new tag: dirty line evicted before refill
    accept(3'd0, 32'h0000_3138);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("evict_lat", 32'(lat), 32'd10);
    check("evict_nwr", 32'(nwr), 32'd1);
    check("evict_nrd", 32'(nrd), 32'd1);
    check("evict_wr_first", 32'(wf), 32'd1);
    complete();

    // Write hit makes idx 3 dirty again
    accept(3'd1, 32'h0000_3138);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("wrhit_lat", 32'(lat), 32'd3);
    check("wrhit_wben", 32'(wb), 32'h0F00);
    complete();

    // Eviction with memreq_rdy stalled in ER
    memreq_rdy = 1'b0;
    accept(3'd0, 32'h0000_3238);
    tick();
    check("ep_ren", 32'(data_array_ren), 32'd1);
    tick();
    check("er_val", 32'(memreq_val), 32'd1);
    check("er_type", 32'(memreq_type), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("er_stall_val", 32'(memreq_val), 32'd1);
      check("er_stall_sel", 32'(memreq_tag_mux_sel), 32'd0);
    end
    memreq_rdy = 1'b1;
    tick();
    check("ew_memresp_rdy", 32'(memresp_rdy), 32'd1);
    check("ew_memreq_val", 32'(memreq_val), 32'd0);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("stall_nrd", 32'(nrd), 32'd1);
    check("stall_nwr", 32'(nwr), 32'd0);
    complete();

    // Response stall with a new request pending
    cacheresp_rdy = 1'b0;
    accept(3'd0, 32'h0000_3238);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("rs_lat", 32'(lat), 32'd3);
    cachereq_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rs_resp_val", 32'(cacheresp_val), 32'd1);
      check("rs_req_rdy", 32'(cachereq_rdy), 32'd0);
      check("rs_req_en", 32'(cachereq_en), 32'd0);
    end
    cacheresp_rdy = 1'b1;
    tick();
    check("rs_next_en", 32'(cachereq_en), 32'd1);
    tick();
    cachereq_val = 1'b0;
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("rs_next_lat", 32'(lat), 32'd3);
    complete();

    // Reset while waiting for a refill in RW
    memresp_val = 1'b0;
    accept(3'd0, 32'h0000_2420);
    tick(); tick();
    check("rw_memresp_rdy", 32'(memresp_rdy), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_rw_memresp_rdy", 32'(memresp_rdy), 32'd0);
    check("rst_rw_memreq", 32'(memreq_val), 32'd0);
    tick();
    check("rst_rw_idle", 32'(cachereq_rdy), 32'd1);
    reset = 1'b0;
    memresp_val = 1'b1;
    tick();
    accept(3'd0, 32'h0000_1004);
    wait_resp(lat, nrd, nwr, wf, wb, rt, rs);
    check("post_rst_nrd", 32'(nrd), 32'd1);
    check("post_rst_nwr", 32'(nwr), 32'd0);
    check("post_rst_lat", 32'(lat), 32'd7);
    complete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
